// File: rtl/calib_slave_fsm.sv
// Follower-side AIB calibration sequencer: answers the leader's DCC/DLL lock
// handshake and raises the transfer enables once the PHY reports lock.
module calib_slave_fsm #(
    parameter int unsigned TOTAL_CHNL_NUM = 24,
    parameter int unsigned CLK_FREQ_MHZ   = 100,
    parameter int unsigned LOCK_TIMEOUT   = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_conf_done,
    input  logic [TOTAL_CHNL_NUM-1:0] ns_mac_rdy,
    input  logic [TOTAL_CHNL_NUM-1:0] ns_adapter_rstn,
    input  logic [TOTAL_CHNL_NUM-1:0] ms_rx_dcc_dll_lock_req,
    input  logic [TOTAL_CHNL_NUM-1:0] ms_tx_dcc_dll_lock_req,
    input  logic [TOTAL_CHNL_NUM-1:0] phy_rx_lock,
    input  logic [TOTAL_CHNL_NUM-1:0] phy_tx_lock,
    output logic [TOTAL_CHNL_NUM-1:0] sl_rx_dcc_dll_lock_req,
    output logic [TOTAL_CHNL_NUM-1:0] sl_tx_dcc_dll_lock_req,
    output logic [TOTAL_CHNL_NUM-1:0] sl_rx_transfer_en,
    output logic [TOTAL_CHNL_NUM-1:0] sl_tx_transfer_en,
    output logic                      calib_done,
    output logic                      calib_fail,
    output logic [2:0]                fsm_state
);

    localparam int unsigned N       = TOTAL_CHNL_NUM;
    localparam int unsigned CNT_MAX = (CLK_FREQ_MHZ > LOCK_TIMEOUT) ? CLK_FREQ_MHZ : LOCK_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RSTN_LAST = CNT_W'(CLK_FREQ_MHZ - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_CONF = 3'd1,
        ST_WAIT_RSTN = 3'd2,
        ST_WAIT_REQ  = 3'd3,
        ST_LOCK_WAIT = 3'd4,
        ST_LINK_UP   = 3'd5,
        ST_FAIL      = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;

    logic         w_conf_ok, w_rstn_ok, w_req_ok, w_lock_ok;
    logic [N-1:0] r_lock_req, w_lock_req;
    logic [N-1:0] r_xfer_en, w_xfer_en;
    logic         r_done, w_done;
    logic         r_fail, w_fail;

    assign w_conf_ok = i_conf_done & (&ns_mac_rdy);
    assign w_rstn_ok = &ns_adapter_rstn;
    assign w_req_ok  = (&ms_rx_dcc_dll_lock_req) & (&ms_tx_dcc_dll_lock_req);
    assign w_lock_ok = (&phy_rx_lock) & (&phy_tx_lock);

    // Next state with abort priority, plus output decode of that next state
    always_comb begin
        w_next_state = r_state;
        w_lock_req   = '0;
        w_xfer_en    = '0;
        w_done       = 1'b0;
        w_fail       = 1'b0;

        case (r_state)
            ST_IDLE:      w_next_state = ST_WAIT_CONF;
            ST_WAIT_CONF: if (w_conf_ok) w_next_state = ST_WAIT_RSTN;
            ST_WAIT_RSTN: begin
                if (!w_conf_ok)                          w_next_state = ST_WAIT_CONF;
                else if (w_rstn_ok && r_cnt == RSTN_LAST) w_next_state = ST_WAIT_REQ;
            end
            ST_WAIT_REQ: begin
                if (!w_conf_ok)      w_next_state = ST_WAIT_CONF;
                else if (!w_rstn_ok) w_next_state = ST_WAIT_RSTN;
                else if (w_req_ok)   w_next_state = ST_LOCK_WAIT;
            end
            ST_LOCK_WAIT: begin
                if (!w_conf_ok)               w_next_state = ST_WAIT_CONF;
                else if (!w_rstn_ok)          w_next_state = ST_WAIT_RSTN;
                else if (!w_req_ok)           w_next_state = ST_WAIT_REQ;
                else if (w_lock_ok)           w_next_state = ST_LINK_UP;
                else if (r_cnt == LOCK_LAST)  w_next_state = ST_FAIL;
            end
            ST_LINK_UP: begin
                if (!w_conf_ok)      w_next_state = ST_WAIT_CONF;
                else if (!w_rstn_ok) w_next_state = ST_WAIT_RSTN;
                else if (!w_req_ok)  w_next_state = ST_WAIT_REQ;
            end
            ST_FAIL:      if (!w_conf_ok) w_next_state = ST_WAIT_CONF;
            default:      w_next_state = ST_IDLE;
        endcase

        case (w_next_state)
            ST_LOCK_WAIT: w_lock_req = '1;
            ST_LINK_UP: begin
                w_lock_req = '1;
                w_xfer_en  = '1;
                w_done     = 1'b1;
            end
            ST_FAIL:      w_fail = 1'b1;
            default:      ;
        endcase
    end

    // State, dwell counter and outputs all update on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_lock_req <= '0;
            r_xfer_en  <= '0;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_lock_req <= w_lock_req;
            r_xfer_en  <= w_xfer_en;
            r_done     <= w_done;
            r_fail     <= w_fail;
            if (w_next_state != r_state)
                r_cnt <= '0;
            else if (r_state == ST_WAIT_RSTN && !w_rstn_ok)
                r_cnt <= '0;
            else if (r_cnt != CNT_W'(CNT_MAX))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign sl_rx_dcc_dll_lock_req = r_lock_req;
    assign sl_tx_dcc_dll_lock_req = r_lock_req;
    assign sl_rx_transfer_en      = r_xfer_en;
    assign sl_tx_transfer_en      = r_xfer_en;
    assign calib_done             = r_done;
    assign calib_fail             = r_fail;
    assign fsm_state              = r_state;

endmodule

// File: tb/tb_calib_slave_fsm.sv
// Scoreboard bench for calib_slave_fsm: directed stimulus pushes expected
// state/outputs, a negedge monitor pops and compares them.
module tb_calib_slave_fsm;

    localparam int unsigned N  = 24;
    localparam int unsigned OW = 4 * N + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_conf_done;
    logic [N-1:0] ns_mac_rdy, ns_adapter_rstn;
    logic [N-1:0] ms_rx_req, ms_tx_req, phy_rx_lock, phy_tx_lock;
    logic [N-1:0] sl_rx_req, sl_tx_req, sl_rx_en, sl_tx_en;
    logic         calib_done, calib_fail;
    logic [2:0]   fsm_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0]    q_state[$];
    logic [OW-1:0] q_out[$];
    string         q_name[$];

    calib_slave_fsm #(
        .TOTAL_CHNL_NUM(N),
        .CLK_FREQ_MHZ  (4),
        .LOCK_TIMEOUT  (8)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .i_conf_done            (i_conf_done),
        .ns_mac_rdy             (ns_mac_rdy),
        .ns_adapter_rstn        (ns_adapter_rstn),
        .ms_rx_dcc_dll_lock_req (ms_rx_req),
        .ms_tx_dcc_dll_lock_req (ms_tx_req),
        .phy_rx_lock            (phy_rx_lock),
        .phy_tx_lock            (phy_tx_lock),
        .sl_rx_dcc_dll_lock_req (sl_rx_req),
        .sl_tx_dcc_dll_lock_req (sl_tx_req),
        .sl_rx_transfer_en      (sl_rx_en),
        .sl_tx_transfer_en      (sl_tx_en),
        .calib_done             (calib_done),
        .calib_fail             (calib_fail),
        .fsm_state              (fsm_state)
    );

    always #5 clk = ~clk;

    // Expected outputs for a given state, straight from the state table
    function automatic logic [OW-1:0] exp_out(input logic [2:0] st);
        logic [N-1:0] ones;
        logic [N-1:0] zero;
        ones = '1;
        zero = '0;
        case (st)
            3'd4:    return {ones, ones, zero, zero, 2'b00};
            3'd5:    return {ones, ones, ones, ones, 2'b10};
            3'd6:    return {zero, zero, zero, zero, 2'b01};
            default: return '0;
        endcase
    endfunction

    task automatic expect_st(input string name, input logic [2:0] st);
        q_name.push_back(name);
        q_state.push_back(st);
        q_out.push_back(exp_out(st));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every pending expectation is checked against the settled outputs
    always @(negedge clk) begin
        while (q_name.size() > 0) begin
            string         nm;
            logic [2:0]    es;
            logic [OW-1:0] eo;
            logic [OW-1:0] got;
            nm  = q_name.pop_front();
            es  = q_state.pop_front();
            eo  = q_out.pop_front();
            got = {sl_rx_req, sl_tx_req, sl_rx_en, sl_tx_en, calib_done, calib_fail};
            n_tests++;
            if (fsm_state !== es) begin
                n_fail++;
                $display("FAIL %s state: got %0d expected %0d", nm, fsm_state, es);
            end
            n_tests++;
            if (got !== eo) begin
                n_fail++;
                $display("FAIL %s outputs: got %h expected %h", nm, got, eo);
            end
        end
    end

    initial begin
        rst             = 1'b1;
        i_conf_done     = 1'b1;
        ns_mac_rdy      = '1;
        ns_adapter_rstn = '1;
        ms_rx_req       = '1;
        ms_tx_req       = '1;
        phy_rx_lock     = '1;
        phy_tx_lock     = '1;
        tick(2);
        expect_st("reset", 3'd0);

        // Nominal bring-up, CLK_FREQ_MHZ = 4
        rst = 1'b0;
        tick(1); expect_st("edge1_wait_conf", 3'd1);
        tick(1); expect_st("edge2_wait_rstn", 3'd2);
        tick(3); expect_st("edge5_still_rstn", 3'd2);
        tick(1); expect_st("edge6_wait_req", 3'd3);
        tick(1); expect_st("edge7_lock_req", 3'd4);
        tick(1); expect_st("edge8_link_up", 3'd5);

        // Link-up abort on a single request bit
        ms_rx_req[5] = 1'b0;
        tick(1); expect_st("req_drop_wait_req", 3'd3);
        ms_rx_req[5] = 1'b1;
        tick(1); expect_st("req_back_lock_wait", 3'd4);
        tick(1); expect_st("req_back_link_up", 3'd5);

        // Lock timeout with TX lock missing
        phy_tx_lock  = '0;
        ms_tx_req[0] = 1'b0;
        tick(1); expect_st("to_wait_req", 3'd3);
        ms_tx_req[0] = 1'b1;
        tick(1); expect_st("lw_enter", 3'd4);
        tick(7); expect_st("lw_cycle7", 3'd4);
        tick(1); expect_st("timeout_fail", 3'd6);
        ns_adapter_rstn[3] = 1'b0;
        tick(1); expect_st("fail_ignores_rstn", 3'd6);
        ns_adapter_rstn[3] = 1'b1;
        i_conf_done = 1'b0;
        tick(1); expect_st("fail_conf_drop", 3'd1);
        i_conf_done = 1'b1;
        tick(1); expect_st("conf_back_rstn", 3'd2);

        // Adapter-reset glitch restarts the settle count
        tick(2);
        ns_adapter_rstn[0] = 1'b0;
        tick(1); expect_st("rstn_glitch", 3'd2);
        ns_adapter_rstn[0] = 1'b1;
        tick(3); expect_st("rstn_count3", 3'd2);
        tick(1); expect_st("rstn_done_wait_req", 3'd3);

        // Lock arriving on the timeout cycle wins
        tick(1); expect_st("coin_lw_enter", 3'd4);
        tick(7); expect_st("coin_lw_cycle7", 3'd4);
        phy_tx_lock = '1;
        tick(1); expect_st("coin_link_up", 3'd5);

        // Adapter-reset abort from LINK_UP
        ns_adapter_rstn[23] = 1'b0;
        tick(1); expect_st("lu_rstn_abort", 3'd2);
        ns_adapter_rstn[23] = 1'b1;
        tick(4); expect_st("lu_rstn_wait_req", 3'd3);
        tick(1); expect_st("lu_rstn_lock_wait", 3'd4);
        tick(1); expect_st("lu_rstn_link_up", 3'd5);

        // MAC-ready drop is a CONF_OK abort
        ns_mac_rdy[11] = 1'b0;
        tick(1); expect_st("mac_drop_wait_conf", 3'd1);
        tick(1); expect_st("mac_drop_hold", 3'd1);
        ns_mac_rdy[11] = 1'b1;
        tick(1); expect_st("mac_back_rstn", 3'd2);

        // Mid-operation reset from LOCK_WAIT
        phy_rx_lock = '0;
        tick(4); expect_st("mr_wait_req", 3'd3);
        tick(1); expect_st("mr_lock_wait", 3'd4);
        tick(2); expect_st("mr_lock_hold", 3'd4);
        rst = 1'b1;
        tick(1); expect_st("mr_reset_idle", 3'd0);
        rst = 1'b0;
        tick(1); expect_st("mr_release_wait_conf", 3'd1);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
